// File: rtl/alu_multicycle_pkg.sv
// Shared definitions for the multicycle ALU: opcode mnemonics, FSM states and
// a small opcode classification helper.
package alu_multicycle_pkg;

   localparam int OP_W = 4;

   // Encodings 12..15 are unused and decode as illegal ops.
   typedef enum logic [OP_W-1:0] {
      NOP    = 4'd0,
      CLB    = 4'd1,
      ADD    = 4'd2,
      SUB    = 4'd3,
      ORR    = 4'd4,
      AND    = 4'd5,
      XOR    = 4'd6,
      LSH    = 4'd7,
      RXOR_7 = 4'd8,
      RXOR_8 = 4'd9,
      MUL    = 4'd10,
      DIVU   = 4'd11
   } op_mne;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } alu_state_t;

   function automatic logic is_multi(input logic [OP_W-1:0] op);
      return (op == MUL) || (op == DIVU);
   endfunction

endpackage

// File: rtl/alu_multicycle_cla.sv
// N-bit carry-lookahead adder: every carry is a flattened generate/propagate
// sum of products, so no carry ripples through sum logic.
module carry_lookahead_adder #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);

   logic [N-1:0] g;
   logic [N-1:0] p;
   logic [N:0]   c;
   logic         pp;

   assign g = a & b;
   assign p = a ^ b;

   always_comb begin
      c  = '0;
      pp = 1'b0;
      c[0] = cin;
      for (int i = 0; i < N; i++) begin
         c[i+1] = g[i];
         pp     = p[i];
         for (int j = i - 1; j >= 0; j--) begin
            c[i+1] = c[i+1] | (pp & g[j]);
            pp     = pp & p[j];
         end
         c[i+1] = c[i+1] | (pp & cin);
      end
   end

   assign sum  = p ^ c[N-1:0];
   assign cout = c[N];

endmodule

// File: rtl/alu_multicycle.sv
// Registered W-bit ALU with valid/ready handshake. Single-cycle ops answer the
// cycle after accept; MUL (shift-add) and DIVU (restoring) answer W+1 cycles after.
module alu_multicycle
   import alu_multicycle_pkg::*;
#(
   parameter  int W     = 8,
   localparam int CNT_W = $clog2(W + 1)
) (
   input  logic            Clk,
   input  logic            Reset_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [W-1:0]    A,
   input  logic [W-1:0]    B,
   input  logic [OP_W-1:0] ALU_OP,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [W-1:0]    Out,
   output logic [W-1:0]    Hi,
   output logic            Zero,
   output logic            Carry,
   output logic            Neg,
   output logic            DivZ,
   output logic            Err,
   output logic [1:0]      dbg_state
);

   // Handshake: an op transfers on in_valid & in_ready; a result transfers on
   // out_valid & out_ready. out_valid holds, with Out/Hi/flags frozen, until taken.

   localparam logic [W-1:0]     W_VAL = W'(W);
   localparam logic [CNT_W-1:0] W_CNT = CNT_W'(W);

   alu_state_t     state, state_n;
   logic [W-1:0]   a_q, a_n;
   logic [W-1:0]   b_q, b_n;
   logic [W-1:0]   acc, acc_n;
   logic [W-1:0]   lo, lo_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic           div_q, div_n;
   logic [W-1:0]   out_q, out_n;
   logic [W-1:0]   hi_q, hi_n;
   logic           zero_q, zero_n;
   logic           carry_q, carry_n;
   logic           neg_q, neg_n;
   logic           divz_q, divz_n;
   logic           err_q, err_n;

   logic           accept;
   logic [W-1:0]   add_a, add_b, add_sum;
   logic           add_cin, add_cout;
   logic [W-1:0]   s_out;
   logic           s_carry, s_err;
   logic           div_ge;

   carry_lookahead_adder #(.N(W)) u_adder (
      .a    (add_a),
      .b    (add_b),
      .cin  (add_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state   <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc     <= '0;
         lo      <= '0;
         cnt     <= '0;
         div_q   <= 1'b0;
         out_q   <= '0;
         hi_q    <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         neg_q   <= 1'b0;
         divz_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_n;
         a_q     <= a_n;
         b_q     <= b_n;
         acc     <= acc_n;
         lo      <= lo_n;
         cnt     <= cnt_n;
         div_q   <= div_n;
         out_q   <= out_n;
         hi_q    <= hi_n;
         zero_q  <= zero_n;
         carry_q <= carry_n;
         neg_q   <= neg_n;
         divz_q  <= divz_n;
         err_q   <= err_n;
      end
   end

   always_comb begin
      state_n = state;
      a_n     = a_q;
      b_n     = b_q;
      acc_n   = acc;
      lo_n    = lo;
      cnt_n   = cnt;
      div_n   = div_q;
      out_n   = out_q;
      hi_n    = hi_q;
      zero_n  = zero_q;
      carry_n = carry_q;
      neg_n   = neg_q;
      divz_n  = divz_q;
      err_n   = err_q;

      in_ready = Reset_n & ((state == IDLE) | ((state == DONE) & out_ready));
      accept   = in_valid & in_ready;

      // The one adder serves the iteration while in CALC, the issuing op otherwise.
      if (state == CALC) begin
         if (div_q) begin
            add_a   = {acc[W-2:0], lo[W-1]};
            add_b   = ~b_q;
            add_cin = 1'b1;
         end else begin
            add_a   = acc;
            add_b   = lo[0] ? a_q : '0;
            add_cin = 1'b0;
         end
      end else begin
         add_a   = A;
         add_b   = (ALU_OP == SUB) ? ~B : B;
         add_cin = (ALU_OP == SUB);
      end

      s_out   = '0;
      s_carry = 1'b0;
      s_err   = 1'b0;
      case (ALU_OP)
         NOP:    s_out = A;
         CLB:    s_out = {1'b0, A[W-2:0]};
         ADD, SUB: begin
            s_out   = add_sum;
            s_carry = add_cout;
         end
         ORR:    s_out = A | B;
         AND:    s_out = A & B;
         XOR:    s_out = A ^ B;
         LSH:    s_out = (A >= W_VAL) ? '0 : (B << A[CNT_W-1:0]);
         RXOR_7: s_out = {{(W-1){1'b0}}, ^A[W-2:0]};
         RXOR_8: s_out = {{(W-1){1'b0}}, ^A};
         MUL, DIVU: s_err = 1'b0;
         default: s_err = 1'b1;
      endcase

      // Shifted partial remainder is W+1 bits; its top bit alone guarantees a fit.
      div_ge = acc[W-1] | add_cout;

      if (state == CALC) begin
         if (cnt == W_CNT) begin
            state_n = DONE;
            out_n   = lo;
            hi_n    = acc;
            zero_n  = (lo == '0);
            carry_n = 1'b0;
            neg_n   = lo[W-1];
            divz_n  = div_q & (b_q == '0);
            err_n   = 1'b0;
         end else begin
            cnt_n = cnt + 1'b1;
            if (div_q) begin
               acc_n = div_ge ? add_sum : {acc[W-2:0], lo[W-1]};
               lo_n  = {lo[W-2:0], div_ge};
            end else begin
               acc_n = {add_cout, add_sum[W-1:1]};
               lo_n  = {add_sum[0], lo[W-1:1]};
            end
         end
      end else if (accept) begin
         a_n = A;
         b_n = B;
         if (is_multi(ALU_OP)) begin
            state_n = CALC;
            cnt_n   = '0;
            acc_n   = '0;
            div_n   = (ALU_OP == DIVU);
            lo_n    = (ALU_OP == DIVU) ? A : B;
         end else begin
            state_n = DONE;
            out_n   = s_out;
            hi_n    = '0;
            zero_n  = (s_out == '0);
            carry_n = s_carry;
            neg_n   = s_out[W-1];
            divz_n  = 1'b0;
            err_n   = s_err;
         end
      end else if (state == DONE) begin
         if (out_ready) state_n = IDLE;
      end else if (state != IDLE) begin
         state_n = IDLE;
      end
   end

   assign out_valid = (state == DONE);
   assign Out       = out_q;
   assign Hi        = hi_q;
   assign Zero      = zero_q;
   assign Carry     = carry_q;
   assign Neg       = neg_q;
   assign DivZ      = divz_q;
   assign Err       = err_q;
   assign dbg_state = state;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle at W=8: single-cycle ops, MUL/DIVU latency,
// backpressure, back-to-back issue and reset in the middle of a multiply.
module tb_alu_multicycle;
   import alu_multicycle_pkg::*;

   localparam int W = 8;

   logic         Clk;
   logic         Reset_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [3:0]   ALU_OP;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] Out;
   logic [W-1:0] Hi;
   logic         Zero, Carry, Neg, DivZ, Err;
   logic [1:0]   dbg_state;

   int n_assert = 0;
   int n_fail   = 0;
   logic [W-1:0] exp_q[$];

   alu_multicycle #(.W(W)) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .ALU_OP    (ALU_OP),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Out       (Out),
      .Hi        (Hi),
      .Zero      (Zero),
      .Carry     (Carry),
      .Neg       (Neg),
      .DivZ      (DivZ),
      .Err       (Err),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      ALU_OP   = op;
      A        = a;
      B        = b;
      in_valid = 1'b1;
   endtask

   // Scoreboard: Out comes from the expected queue; flags are {Zero,Carry,Neg,DivZ,Err}.
   task automatic check_out(input string tag, input logic [W-1:0] exp_hi, input logic [4:0] exp_flags);
      logic [W-1:0] exp_out;
      exp_out = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      check({tag, "_valid"}, 16'(out_valid), 16'd1);
      check({tag, "_out"},   16'(Out),       16'(exp_out));
      check({tag, "_hi"},    16'(Hi),        16'(exp_hi));
      check({tag, "_flags"}, 16'({Zero, Carry, Neg, DivZ, Err}), 16'(exp_flags));
   endtask

   task automatic single(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_out,
                         input logic [4:0] exp_flags);
      exp_q.push_back(exp_out);
      drive(op, a, b);
      step();
      in_valid = 1'b0;
      check_out(tag, '0, exp_flags);
      step();
   endtask

   task automatic multi(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_out,
                        input logic [W-1:0] exp_hi, input logic [4:0] exp_flags);
      int   lat;
      logic rdy_seen;
      exp_q.push_back(exp_out);
      drive(op, a, b);
      step();
      in_valid = 1'b0;
      lat      = 0;
      rdy_seen = 1'b0;
      while (!out_valid && lat < 30) begin
         if (in_ready) rdy_seen = 1'b1;
         A = W'($urandom_range(0, 255));
         B = W'($urandom_range(0, 255));
         step();
         lat++;
      end
      check({tag, "_latency"}, 16'(lat), 16'd9);
      check({tag, "_ready_in_calc"}, 16'(rdy_seen), 16'd0);
      check_out(tag, exp_hi, exp_flags);
      step();
   endtask

   initial begin
      Reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      A         = '0;
      B         = '0;
      ALU_OP    = NOP;

      // reset state
      step();
      step();
      check("rst_valid", 16'(out_valid), 16'd0);
      check("rst_out", 16'(Out), 16'd0);
      check("rst_hi", 16'(Hi), 16'd0);
      check("rst_flags", 16'({Zero, Carry, Neg, DivZ, Err}), 16'd0);
      check("rst_in_ready", 16'(in_ready), 16'd0);
      check("rst_state", 16'(dbg_state), 16'(IDLE));
      Reset_n = 1'b1;
      step();
      check("post_rst_in_ready", 16'(in_ready), 16'd1);

      // single-cycle ops
      single("add_200_100", ADD, 8'd200, 8'd100, 8'd44, 5'b01000);
      single("sub_5_5", SUB, 8'd5, 8'd5, 8'd0, 5'b11000);
      single("sub_3_5", SUB, 8'd3, 8'd5, 8'd254, 5'b00100);
      single("lsh_2", LSH, 8'd2, 8'd3, 8'd12, 5'b00000);
      single("lsh_16", LSH, 8'd16, 8'd3, 8'd0, 5'b10000);
      single("clb", CLB, 8'hFF, 8'h00, 8'h7F, 5'b00000);
      single("rxor7", RXOR_7, 8'h81, 8'h00, 8'h01, 5'b00000);
      single("rxor8", RXOR_8, 8'h81, 8'h00, 8'h00, 5'b10000);
      single("xor", XOR, 8'hF0, 8'h3C, 8'hCC, 5'b00100);
      single("illegal", 4'hF, 8'h12, 8'h34, 8'h00, 5'b10001);

      // back-to-back issue with out_ready held high
      exp_q.push_back(8'h30);
      exp_q.push_back(8'hFC);
      exp_q.push_back(8'h55);
      drive(AND, 8'hF0, 8'h3C);
      step();
      drive(ORR, 8'hF0, 8'h3C);
      check("b2b_in_ready", 16'(in_ready), 16'd1);
      check_out("b2b_and", '0, 5'b00000);
      step();
      drive(NOP, 8'h55, 8'hAA);
      check_out("b2b_orr", '0, 5'b00100);
      step();
      in_valid = 1'b0;
      check_out("b2b_nop", '0, 5'b00000);
      step();
      check("b2b_idle", 16'(dbg_state), 16'(IDLE));

      // iterative ops
      multi("mul_200_200", MUL, 8'd200, 8'd200, 8'h40, 8'h9C, 5'b00000);
      multi("mul_255_255", MUL, 8'd255, 8'd255, 8'h01, 8'hFE, 5'b00000);
      multi("divu_100_7", DIVU, 8'd100, 8'd7, 8'd14, 8'd2, 5'b00000);
      multi("divu_by_0", DIVU, 8'd100, 8'd0, 8'hFF, 8'd100, 5'b00110);

      // backpressure: result held while A/B wander
      out_ready = 1'b0;
      exp_q.push_back(8'd2);
      drive(ADD, 8'd1, 8'd1);
      step();
      for (int i = 0; i < 3; i++) begin
         A = W'($urandom_range(0, 255));
         B = W'($urandom_range(0, 255));
         check("bp_out", 16'(Out), 16'd2);
         check("bp_in_ready", 16'(in_ready), 16'd0);
         check("bp_valid", 16'(out_valid), 16'd1);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check_out("bp_ack", '0, 5'b00000);
      step();
      check("bp_idle", 16'(dbg_state), 16'(IDLE));
      check("bp_valid_drop", 16'(out_valid), 16'd0);

      // reset on the 4th CALC cycle of a multiply
      drive(MUL, 8'd200, 8'd200);
      step();
      in_valid = 1'b0;
      step();
      step();
      step();
      check("mrst_in_calc", 16'(dbg_state), 16'(CALC));
      Reset_n = 1'b0;
      step();
      check("mrst_valid", 16'(out_valid), 16'd0);
      check("mrst_out", 16'(Out), 16'd0);
      check("mrst_in_ready", 16'(in_ready), 16'd0);
      check("mrst_state", 16'(dbg_state), 16'(IDLE));
      Reset_n = 1'b1;
      step();
      single("add_after_rst", ADD, 8'd7, 8'd8, 8'd15, 5'b00000);

      check("scoreboard_empty", 16'(exp_q.size()), 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
